// File: rtl/tpu_pkg.sv
// Shared state encoding and default widths for the TPU run sequencer slice.
package tpu_pkg;

    localparam int unsigned DEF_ADDRESSSIZE    = 10;
    localparam int unsigned DEF_DATA_BW        = 8;
    localparam int unsigned DEF_MATRIX_SIZE    = 32;
    localparam int unsigned DEF_PARTIAL_SUM_BW = 24;
    localparam int unsigned DEF_WGT_TILES      = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_ACT,
        LOAD_WGT,
        ARM,
        FEED,
        WAIT_END,
        CHK_ADDR,
        CHK_CMP,
        DONE
    } seq_state_e;

endpackage

// File: rtl/tpu_run_sequencer_if.sv
// Activation, weight and expected-result valid/ready streams into the sequencer.
interface tpu_run_sequencer_if
    import tpu_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int unsigned DATA_BW        = DEF_DATA_BW,
    parameter int unsigned PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW
) ();

    logic                                     act_valid;
    logic                                     act_ready;
    logic [MATRIX_SIZE*DATA_BW-1:0]           act_data;
    logic                                     wgt_valid;
    logic                                     wgt_ready;
    logic [DATA_BW*MATRIX_SIZE*MATRIX_SIZE-1:0] wgt_data;
    logic                                     exp_valid;
    logic                                     exp_ready;
    logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0]    exp_data;

    // Source side: the host supplying rows, weights and expected results
    modport master (
        output act_valid, act_data, wgt_valid, wgt_data, exp_valid, exp_data,
        input  act_ready, wgt_ready, exp_ready
    );

    // Sink side: the sequencer
    modport slave (
        input  act_valid, act_data, wgt_valid, wgt_data, exp_valid, exp_data,
        output act_ready, wgt_ready, exp_ready
    );

endinterface

// File: rtl/tpu_row_checker.sv
// Compares one result row against its expected row and keeps a saturating mismatch count.
module tpu_row_checker
    import tpu_pkg::*;
#(
    parameter int unsigned MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int unsigned PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int unsigned CNT_W          = DEF_ADDRESSSIZE + 1
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  clear,
    input  logic                                  cmp_en,
    input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] result_row,
    input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] exp_row,
    output logic                                  mismatch_c,
    output logic [CNT_W-1:0]                      err_count
);

    // Row inequality, valid whenever both rows are presented
    always_comb begin
        mismatch_c = (result_row != exp_row);
    end

    // Error counter: cleared at run start, counts mismatches, stops at M
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_count <= '0;
        end else if (clear) begin
            err_count <= '0;
        end else if (cmp_en && mismatch_c && (err_count < CNT_W'(MATRIX_SIZE))) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tpu_run_sequencer.sv
// Sequences one systolic-array run: load activations and weights, arm, feed,
// wait for completion, optionally check result rows, then report status.
module tpu_run_sequencer
    import tpu_pkg::*;
#(
    parameter int unsigned ADDRESSSIZE    = DEF_ADDRESSSIZE,
    parameter int unsigned DATA_BW        = DEF_DATA_BW,
    parameter int unsigned MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int unsigned PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int unsigned WGT_TILES      = DEF_WGT_TILES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      go,
    input  logic                                      check_en,
    input  logic                                      abort,
    tpu_run_sequencer_if.slave                        bus,
    output logic                                      sram_write_enable,
    output logic [ADDRESSSIZE-1:0]                    sram_address,
    output logic [MATRIX_SIZE*DATA_BW-1:0]            sram_data_in,
    output logic                                      fifo_write_enable,
    output logic [DATA_BW*MATRIX_SIZE*MATRIX_SIZE-1:0] fifo_data_in,
    output logic                                      fifo_read_enable,
    output logic                                      we_rl,
    output logic                                      start,
    output logic                                      valid_address,
    input  logic                                      end_,
    output logic [ADDRESSSIZE-1:0]                    result_address,
    input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0]     result_data,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      pass,
    output logic                                      timeout,
    output logic [ADDRESSSIZE:0]                      err_count
);

    localparam int unsigned ROW_W  = $clog2(MATRIX_SIZE) + 1;
    localparam int unsigned TILE_W = $clog2(WGT_TILES) + 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned CNT_W  = ADDRESSSIZE + 1;

    seq_state_e        st;
    logic [ROW_W-1:0]  row;
    logic [TILE_W-1:0] tile;
    logic [TO_W-1:0]   wait_cnt;
    logic              chk_en;
    logic [1:0]        end_q;
    logic              end_rise_c;
    logic              clear_c;
    logic              cmp_en_c;
    logic              mismatch_c;

    // Control strobes for the row checker and the registered end_ edge
    always_comb begin
        end_rise_c = end_q[0] & ~end_q[1];
        clear_c    = (st == IDLE) && go && !abort;
        cmp_en_c   = (st == CHK_CMP) && bus.exp_valid && bus.exp_ready && !abort;
    end

    tpu_row_checker #(
        .MATRIX_SIZE    (MATRIX_SIZE),
        .PARTIAL_SUM_BW (PARTIAL_SUM_BW),
        .CNT_W          (CNT_W)
    ) u_checker (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (clear_c),
        .cmp_en     (cmp_en_c),
        .result_row (result_data),
        .exp_row    (bus.exp_data),
        .mismatch_c (mismatch_c),
        .err_count  (err_count)
    );

    // Run FSM with all outputs registered; pulses default low every cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st                <= IDLE;
            row               <= '0;
            tile              <= '0;
            wait_cnt          <= '0;
            chk_en            <= 1'b0;
            end_q             <= '0;
            bus.act_ready     <= 1'b0;
            bus.wgt_ready     <= 1'b0;
            bus.exp_ready     <= 1'b0;
            sram_write_enable <= 1'b0;
            sram_address      <= '0;
            sram_data_in      <= '0;
            fifo_write_enable <= 1'b0;
            fifo_data_in      <= '0;
            fifo_read_enable  <= 1'b0;
            we_rl             <= 1'b0;
            start             <= 1'b0;
            valid_address     <= 1'b0;
            result_address    <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            pass              <= 1'b0;
            timeout           <= 1'b0;
        end else begin
            end_q             <= {end_q[0], end_};
            sram_write_enable <= 1'b0;
            fifo_write_enable <= 1'b0;
            fifo_read_enable  <= 1'b0;
            we_rl             <= 1'b0;
            done              <= 1'b0;
            valid_address     <= 1'b0;
            sram_address      <= '0;

            if (abort) begin
                st            <= IDLE;
                bus.act_ready <= 1'b0;
                bus.wgt_ready <= 1'b0;
                bus.exp_ready <= 1'b0;
                start         <= 1'b0;
                busy          <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        if (go) begin
                            st            <= LOAD_ACT;
                            chk_en        <= check_en;
                            pass          <= 1'b0;
                            timeout       <= 1'b0;
                            row           <= '0;
                            bus.act_ready <= 1'b1;
                            busy          <= 1'b1;
                        end
                    end
                    LOAD_ACT: begin
                        if (bus.act_valid && bus.act_ready) begin
                            sram_write_enable <= 1'b1;
                            sram_address      <= ADDRESSSIZE'(row);
                            sram_data_in      <= bus.act_data;
                            if (row == ROW_W'(MATRIX_SIZE - 1)) begin
                                st            <= LOAD_WGT;
                                tile          <= '0;
                                bus.act_ready <= 1'b0;
                                bus.wgt_ready <= 1'b1;
                            end else begin
                                row <= row + ROW_W'(1);
                            end
                        end
                    end
                    LOAD_WGT: begin
                        if (bus.wgt_valid && bus.wgt_ready) begin
                            fifo_write_enable <= 1'b1;
                            fifo_data_in      <= bus.wgt_data;
                            if (tile == TILE_W'(WGT_TILES - 1)) begin
                                st               <= ARM;
                                bus.wgt_ready    <= 1'b0;
                                start            <= 1'b1;
                                fifo_read_enable <= 1'b1;
                                we_rl            <= 1'b1;
                            end else begin
                                tile <= tile + TILE_W'(1);
                            end
                        end
                    end
                    ARM: begin
                        st            <= FEED;
                        row           <= '0;
                        valid_address <= 1'b1;
                    end
                    FEED: begin
                        if (row == ROW_W'(MATRIX_SIZE - 1)) begin
                            st       <= WAIT_END;
                            wait_cnt <= '0;
                        end else begin
                            row           <= row + ROW_W'(1);
                            valid_address <= 1'b1;
                            sram_address  <= ADDRESSSIZE'(row + ROW_W'(1));
                        end
                    end
                    WAIT_END: begin
                        if (end_rise_c) begin
                            start <= 1'b0;
                            if (chk_en) begin
                                st             <= CHK_ADDR;
                                row            <= '0;
                                result_address <= '0;
                            end else begin
                                st   <= DONE;
                                done <= 1'b1;
                                pass <= (err_count == '0) && !timeout;
                            end
                        end else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            st      <= DONE;
                            start   <= 1'b0;
                            timeout <= 1'b1;
                            done    <= 1'b1;
                            pass    <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt + TO_W'(1);
                        end
                    end
                    CHK_ADDR: begin
                        st            <= CHK_CMP;
                        bus.exp_ready <= 1'b1;
                    end
                    CHK_CMP: begin
                        if (bus.exp_valid && bus.exp_ready) begin
                            bus.exp_ready <= 1'b0;
                            if (row == ROW_W'(MATRIX_SIZE - 1)) begin
                                st   <= DONE;
                                done <= 1'b1;
                                pass <= (err_count == '0) && !mismatch_c && !timeout;
                            end else begin
                                st             <= CHK_ADDR;
                                row            <= row + ROW_W'(1);
                                result_address <= ADDRESSSIZE'(row + ROW_W'(1));
                            end
                        end
                    end
                    DONE: begin
                        st   <= IDLE;
                        busy <= 1'b0;
                    end
                    default: begin
                        st   <= IDLE;
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tpu_run_sequencer.sv
// Directed bench for tpu_run_sequencer with M=4, identity weights and a modelled result SRAM.
module tb_tpu_run_sequencer;

    localparam int unsigned M   = 4;
    localparam int unsigned DBW = 8;
    localparam int unsigned PBW = 24;
    localparam int unsigned AW  = 10;
    localparam int unsigned NT  = 4;
    localparam int unsigned TO  = 64;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic go = 1'b0;
    logic check_en = 1'b0;
    logic abort = 1'b0;
    logic end_ = 1'b0;
    logic [M*PBW-1:0] result_data = '0;

    logic              sram_write_enable;
    logic [AW-1:0]     sram_address;
    logic [M*DBW-1:0]  sram_data_in;
    logic              fifo_write_enable;
    logic [DBW*M*M-1:0] fifo_data_in;
    logic              fifo_read_enable;
    logic              we_rl;
    logic              start;
    logic              valid_address;
    logic [AW-1:0]     result_address;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [AW:0]       err_count;

    tpu_run_sequencer_if #(.MATRIX_SIZE(M), .DATA_BW(DBW), .PARTIAL_SUM_BW(PBW)) bus ();

    tpu_run_sequencer #(
        .ADDRESSSIZE(AW), .DATA_BW(DBW), .MATRIX_SIZE(M), .PARTIAL_SUM_BW(PBW),
        .WGT_TILES(NT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .go(go), .check_en(check_en), .abort(abort),
        .bus(bus),
        .sram_write_enable(sram_write_enable), .sram_address(sram_address),
        .sram_data_in(sram_data_in), .fifo_write_enable(fifo_write_enable),
        .fifo_data_in(fifo_data_in), .fifo_read_enable(fifo_read_enable),
        .we_rl(we_rl), .start(start), .valid_address(valid_address), .end_(end_),
        .result_address(result_address), .result_data(result_data),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count)
    );

    always #5 clk = ~clk;

    logic [M*DBW-1:0]   act_rows [M];
    logic [M*PBW-1:0]   res_mem  [M];
    logic [DBW*M*M-1:0] ident;

    // Result SRAM with one-cycle read latency
    always @(posedge clk) result_data <= res_mem[result_address[1:0]];

    int total = 0;
    int bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic chk);
        go = 1'b1; check_en = chk;
        tick();
        go = 1'b0;
        total++; if ({busy, bus.act_ready} !== 2'b11) begin bad++; $display("FAIL go_accept: got %b want 11", {busy, bus.act_ready}); end
        for (int r = 0; r < M; r++) begin
            bus.act_valid = 1'b1; bus.act_data = act_rows[r];
            tick();
            total++; if ({sram_write_enable, sram_address, sram_data_in} !== {1'b1, AW'(r), act_rows[r]}) begin
                bad++; $display("FAIL sram_write row %0d: got %h want %h", r, {sram_write_enable, sram_address, sram_data_in}, {1'b1, AW'(r), act_rows[r]}); end
        end
        bus.act_valid = 1'b0;
        total++; if ({bus.act_ready, bus.wgt_ready} !== 2'b01) begin bad++; $display("FAIL load_wgt_entry: got %b want 01", {bus.act_ready, bus.wgt_ready}); end
        for (int t = 0; t < NT; t++) begin
            bus.wgt_valid = 1'b1; bus.wgt_data = ident;
            tick();
            total++; if ({fifo_write_enable, fifo_data_in} !== {1'b1, ident}) begin
                bad++; $display("FAIL fifo_write tile %0d: got %h want %h", t, {fifo_write_enable, fifo_data_in}, {1'b1, ident}); end
        end
        bus.wgt_valid = 1'b0;
        total++; if ({start, fifo_read_enable, we_rl, bus.wgt_ready} !== 4'b1110) begin
            bad++; $display("FAIL arm_pulses: got %b want 1110", {start, fifo_read_enable, we_rl, bus.wgt_ready}); end
    endtask

    task automatic do_feed(input logic pulse_go);
        tick();
        for (int i = 0; i < M; i++) begin
            total++; if ({valid_address, start, sram_address} !== {2'b11, AW'(i)}) begin
                bad++; $display("FAIL feed cycle %0d: got %h want %h", i, {valid_address, start, sram_address}, {2'b11, AW'(i)}); end
            if (pulse_go && i == 1) begin go = 1'b1; check_en = 1'b0; end
            tick();
            go = 1'b0;
        end
        total++; if ({valid_address, start, sram_address, fifo_read_enable, we_rl} !== {2'b01, AW'(0), 2'b00}) begin
            bad++; $display("FAIL feed_exit: got %h want %h", {valid_address, start, sram_address, fifo_read_enable, we_rl}, {2'b01, AW'(0), 2'b00}); end
    endtask

    task automatic do_check(input int bad_row, input int gap);
        for (int r = 0; r < M; r++) begin
            int n = 0;
            while (bus.exp_ready !== 1'b1 && n < 50) begin tick(); n++; end
            total++; if ({bus.exp_ready, result_address} !== {1'b1, AW'(r)}) begin
                bad++; $display("FAIL chk_ready row %0d: got %h want %h", r, {bus.exp_ready, result_address}, {1'b1, AW'(r)}); end
            for (int k = 0; k < gap; k++) begin
                tick();
                total++; if ({bus.exp_ready, result_address, done} !== {1'b1, AW'(r), 1'b0}) begin
                    bad++; $display("FAIL chk_hold row %0d: got %h want %h", r, {bus.exp_ready, result_address, done}, {1'b1, AW'(r), 1'b0}); end
            end
            bus.exp_valid = 1'b1;
            bus.exp_data  = (r == bad_row) ? (res_mem[r] ^ (M*PBW)'(32)) : res_mem[r];
            tick();
            bus.exp_valid = 1'b0;
        end
        total++; if ({done, busy} !== 2'b11) begin bad++; $display("FAIL done_pulse: got %b want 11", {done, busy}); end
    endtask

    task automatic finish_run(input logic exp_pass, input int exp_err);
        total++; if ({pass, timeout, err_count} !== {exp_pass, 1'b0, (AW+1)'(exp_err)}) begin
            bad++; $display("FAIL run_status: got %h want %h", {pass, timeout, err_count}, {exp_pass, 1'b0, (AW+1)'(exp_err)}); end
        end_ = 1'b0;
        tick();
        total++; if ({done, busy, pass, err_count} !== {2'b00, exp_pass, (AW+1)'(exp_err)}) begin
            bad++; $display("FAIL run_idle: got %h want %h", {done, busy, pass, err_count}, {2'b00, exp_pass, (AW+1)'(exp_err)}); end
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if ({busy, done, pass, timeout, start, valid_address, sram_address, result_address, err_count} !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {busy, done, pass, timeout, start, valid_address, sram_address, result_address, err_count}); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_match();
        do_load(1'b1); do_feed(1'b0); end_ = 1'b1; do_check(-1, 0); finish_run(1'b1, 0);
    endtask

    task automatic test_corrupt();
        do_load(1'b1); do_feed(1'b0); end_ = 1'b1; do_check(2, 0); finish_run(1'b0, 1);
    endtask

    task automatic test_exp_stall();
        do_load(1'b1); do_feed(1'b0); end_ = 1'b1; do_check(-1, 3); finish_run(1'b1, 0);
    endtask

    task automatic test_timeout();
        int early = 0;
        do_load(1'b1); do_feed(1'b0);
        for (int n = 1; n < TO; n++) begin
            tick();
            if (done !== 1'b0 || start !== 1'b1) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL timeout_early: got %0d bad cycles want 0", early); end
        tick();
        total++; if ({done, timeout, pass, start} !== 4'b1100) begin
            bad++; $display("FAIL timeout_done: got %b want 1100", {done, timeout, pass, start}); end
        tick(); tick();
    endtask

    task automatic test_go_in_feed();
        do_load(1'b1); do_feed(1'b1); end_ = 1'b1; do_check(-1, 0); finish_run(1'b1, 0);
    endtask

    task automatic test_abort();
        int seen = 0;
        go = 1'b1; check_en = 1'b1;
        tick();
        go = 1'b0;
        for (int r = 0; r < M; r++) begin bus.act_valid = 1'b1; bus.act_data = act_rows[r]; tick(); end
        bus.act_valid = 1'b0;
        bus.wgt_valid = 1'b1; bus.wgt_data = ident;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; bus.wgt_valid = 1'b0;
        total++; if ({busy, bus.wgt_ready, fifo_write_enable, start, done} !== 5'b00000) begin
            bad++; $display("FAIL abort_idle: got %b want 00000", {busy, bus.wgt_ready, fifo_write_enable, start, done}); end
        for (int n = 0; n < 8; n++) begin tick(); if (done !== 1'b0 || busy !== 1'b0) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_no_done: got %0d cycles want 0", seen); end
    endtask

    task automatic test_nocheck();
        int n = 0;
        do_load(1'b0); do_feed(1'b0); end_ = 1'b1;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if ({done, pass, bus.exp_ready, start} !== 4'b1100) begin
            bad++; $display("FAIL nocheck_done: got %b want 1100", {done, pass, bus.exp_ready, start}); end
        finish_run(1'b1, 0);
    endtask

    task automatic test_reset_mid();
        do_load(1'b1);
        tick(); tick();
        rstn = 1'b0;
        #1;
        total++; if ({busy, done, pass, timeout, start, valid_address, sram_address, result_address, err_count,
                      sram_write_enable, fifo_write_enable, fifo_read_enable, we_rl, bus.act_ready, bus.wgt_ready, bus.exp_ready} !== '0) begin
            bad++; $display("FAIL reset_mid: got %h want 0", {busy, done, pass, timeout, start, valid_address, sram_address, result_address, err_count}); end
        tick(); tick();
        rstn = 1'b1;
        tick();
        test_match();
    endtask

    initial begin
        bus.act_valid = 1'b0; bus.act_data = '0;
        bus.wgt_valid = 1'b0; bus.wgt_data = '0;
        bus.exp_valid = 1'b0; bus.exp_data = '0;
        act_rows[0] = 32'h04030201;
        act_rows[1] = 32'h80FF7F00;
        act_rows[2] = 32'h11223344;
        act_rows[3] = 32'hA5C30F5A;
        for (int r = 0; r < M; r++)
            for (int e = 0; e < M; e++)
                res_mem[r][e*PBW +: PBW] = PBW'(act_rows[r][e*DBW +: DBW]);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                ident[(i*M+j)*DBW +: DBW] = (i == j) ? 8'd1 : 8'd0;

        test_reset();
        test_match();
        test_corrupt();
        test_exp_stall();
        test_timeout();
        test_go_in_feed();
        test_abort();
        test_nocheck();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
